// File: rtl/sp_ram_pkg.sv
// Shared constants for the sp_ram scratch memory: default geometry and read-mode encodings.
package sp_ram_pkg;

    localparam int unsigned SP_RAM_AW_DEF = 4;
    localparam int unsigned SP_RAM_DW_DEF = 8;

    localparam logic MODE_ASYNC = 1'b0;
    localparam logic MODE_SYNC  = 1'b1;

endpackage

// File: rtl/sp_ram_array.sv
// Storage array for sp_ram: 2^AW x DW words, async-reset clear, one write port, one combinational read port.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int unsigned AW = SP_RAM_AW_DEF,
    parameter int unsigned DW = SP_RAM_DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    // Reset wins over a write on the same edge, so an interrupted write never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sp_ram.sv
// sp_ram top: read register, cs/oe/mode output select. Define SP_RAM_WRITE_FIRST_EN to load write data into the read register.
module sp_ram
    import sp_ram_pkg::*;
#(
    parameter int unsigned AW = SP_RAM_AW_DEF,
    parameter int unsigned DW = SP_RAM_DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    input  logic          we,
    input  logic          cs,
    input  logic          oe,
    input  logic          mode_cs,
    output logic [DW-1:0] data_out
);

    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] arr_rdata;
    logic [DW-1:0] rd_d;
    logic [DW-1:0] rd_q;

    assign wr_en = cs & we;
    assign rd_en = cs & ~we;

    sp_ram_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (wr_en),
        .addr_i  (addr),
        .wdata_i (data_in),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = arr_rdata;
        end
`ifdef SP_RAM_WRITE_FIRST_EN
        else if (wr_en) begin
            rd_d = data_in;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // oe and mode_cs are live selects; sync mode simply exposes whatever rd_q last captured.
    always_comb begin
        data_out = '0;
        if (cs && oe) begin
            if (mode_cs == MODE_SYNC) begin
                data_out = rd_q;
            end else begin
                data_out = arr_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram.sv
// Scoreboard bench for sp_ram: expected read data queued at drive time, popped when the output is sampled.
module tb_sp_ram;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          we;
    logic          cs;
    logic          oe;
    logic          mode_cs;
    logic [DW-1:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    sp_ram #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .we       (we),
        .cs       (cs),
        .oe       (oe),
        .mode_cs  (mode_cs),
        .data_out (data_out)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %h expected scoreboard entry (queue empty)", tag, data_out);
        end else begin
            e = exp_q.pop_front();
            chk(tag, data_out, e);
        end
    endtask

    initial begin
        logic [DW-1:0] wf_exp;
        rst_n = 1'b0; cs = 1'b1; oe = 1'b1; mode_cs = 1'b1; we = 1'b0;
        addr = '0; data_in = '0;

        #1;
        exp_q.push_back(8'h00);
        pop_chk("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sync read sweep straight after reset
        for (int i = 0; i < 16; i++) begin
            addr = AW'(i);
            exp_q.push_back(8'h00);
            @(posedge clk); #1;
            pop_chk("rst_rd");
            @(negedge clk);
        end

        // Write sweep: mem[i] = i+1
        we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr = AW'(i);
            data_in = DW'(i + 1);
            @(negedge clk);
        end
        we = 1'b0;

        // Sync read: one cycle latency
        for (int i = 0; i < 16; i++) begin
            addr = AW'(i);
            exp_q.push_back(DW'(i + 1));
            @(posedge clk); #1;
            pop_chk("sync_rd");
            @(negedge clk);
        end

        // Async read: output follows addr before the next edge
        mode_cs = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            addr = AW'(i);
            exp_q.push_back(DW'(i + 1));
            #1;
            pop_chk("async_rd");
            @(negedge clk);
        end

        // Gating
        cs = 1'b0; addr = 4'd5;
        exp_q.push_back(8'h00); #1; pop_chk("cs0_async");
        cs = 1'b1; oe = 1'b0;
        exp_q.push_back(8'h00); #1; pop_chk("oe0_async");
        mode_cs = 1'b1;
        exp_q.push_back(8'h00); #1; pop_chk("oe0_sync");
        oe = 1'b1;
        @(negedge clk);
        cs = 1'b0; we = 1'b1; addr = 4'd3; data_in = 8'hAA;
        @(negedge clk);
        cs = 1'b1; we = 1'b0; mode_cs = 1'b0;
        exp_q.push_back(8'h04); #1; pop_chk("cs0_nowrite");

        // Same-address write then sync view
        mode_cs = 1'b1; addr = 4'd7;
        exp_q.push_back(8'h08);
        @(posedge clk); #1; pop_chk("pre_wr_rd");
        @(negedge clk);
        we = 1'b1; data_in = 8'h5C;
`ifdef SP_RAM_WRITE_FIRST_EN
        wf_exp = 8'h5C;
`else
        wf_exp = 8'h08;
`endif
        exp_q.push_back(wf_exp);
        @(posedge clk); #1; pop_chk("wr_cycle_sync");
        mode_cs = 1'b0;
        exp_q.push_back(8'h5C); #1; pop_chk("wr_vis_async");
        mode_cs = 1'b1;
        @(negedge clk);
        we = 1'b0;
        exp_q.push_back(8'h5C);
        @(posedge clk); #1; pop_chk("post_wr_sync");

        // Reset between edges, overlapping a pending write
        @(negedge clk);
        we = 1'b1; addr = 4'd2; data_in = 8'h77;
        #5 rst_n = 1'b0;
        exp_q.push_back(8'h00); #1; pop_chk("mid_reset");
        @(posedge clk); #1;
        exp_q.push_back(8'h00); pop_chk("reset_hold");
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0; mode_cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = AW'(i);
            exp_q.push_back(8'h00);
            #1;
            pop_chk("post_rst_async");
        end
        mode_cs = 1'b1; addr = 4'd2;
        exp_q.push_back(8'h00);
        @(posedge clk); #1; pop_chk("post_rst_sync");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: got %0d leftover entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
